// File: rtl/nor_latch.sv
// Clocked bank of NOR-gate SR latch cells with registered q/q_bar rails and forbidden-state flagging.
// Optional saturating forbidden-entry counter enabled by defining NOR_LATCH_VIOL_CNT_EN.
module nor_latch #(
   parameter int unsigned WIDTH = 1
`ifdef NOR_LATCH_VIOL_CNT_EN
   , parameter int unsigned CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [WIDTH-1:0] invalid,
   output logic             err_sticky
`ifdef NOR_LATCH_VIOL_CNT_EN
   , output logic [CNT_W-1:0] viol_cnt
`endif
);

   logic [WIDTH-1:0] q_nx;
   logic [WIDTH-1:0] qb_nx;
   logic [WIDTH-1:0] entry;

   // Derived from registered state only, so there is no path from s/r.
   assign invalid = ~q & ~q_bar;

   always_comb begin
      q_nx  = q;
      qb_nx = q_bar;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         unique case ({s[i], r[i]})
            2'b00: begin
               if (invalid[i]) begin
                  q_nx[i]  = 1'b0;
                  qb_nx[i] = 1'b1;
               end
            end
            2'b01: begin
               q_nx[i]  = 1'b0;
               qb_nx[i] = 1'b1;
            end
            2'b10: begin
               q_nx[i]  = 1'b1;
               qb_nx[i] = 1'b0;
            end
            default: begin
               q_nx[i]  = 1'b0;
               qb_nx[i] = 1'b0;
            end
         endcase
      end
      entry = ~q_nx & ~qb_nx & ~invalid;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q          <= '0;
         q_bar      <= '1;
         err_sticky <= 1'b0;
      end else begin
         q     <= q_nx;
         q_bar <= qb_nx;
         if (|entry)
            err_sticky <= 1'b1;
         else if (err_clr)
            err_sticky <= 1'b0;
      end
   end

`ifdef NOR_LATCH_VIOL_CNT_EN
   localparam int unsigned SUM_W = CNT_W + $clog2(WIDTH + 1) + 1;

   logic [SUM_W-1:0] n_entry;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_nx;

   // err_clr drops the old count but still loads this cycle's entries.
   always_comb begin
      n_entry = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         n_entry = n_entry + SUM_W'(entry[i]);
      sum = (err_clr ? '0 : SUM_W'(viol_cnt)) + n_entry;
      if (sum > SUM_W'({CNT_W{1'b1}}))
         cnt_nx = '1;
      else
         cnt_nx = sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         viol_cnt <= '0;
      else
         viol_cnt <= cnt_nx;
   end
`endif

endmodule

// File: tb/tb_nor_latch.sv
// Directed self-checking bench for nor_latch: a WIDTH=1 cell for the truth table and a
// WIDTH=4 bank for independence and, when NOR_LATCH_VIOL_CNT_EN is defined, the counter.
module tb_nor_latch;

   logic       clk = 1'b0;
   logic       rst_n, rst4_n;
   logic [0:0] s, r, q, q_bar, invalid;
   logic       err_clr, err_sticky;
   logic [3:0] s4, r4, q4, qb4, inv4;
   logic       err_clr4, err4;
`ifdef NOR_LATCH_VIOL_CNT_EN
   logic [15:0] viol1;
   logic [1:0]  viol4;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   nor_latch #(.WIDTH(1)) dut (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .err_clr(err_clr),
      .q(q), .q_bar(q_bar), .invalid(invalid), .err_sticky(err_sticky)
`ifdef NOR_LATCH_VIOL_CNT_EN
      , .viol_cnt(viol1)
`endif
   );

   nor_latch #(
      .WIDTH(4)
`ifdef NOR_LATCH_VIOL_CNT_EN
      , .CNT_W(2)
`endif
   ) dut4 (
      .clk(clk), .rst_n(rst4_n), .s(s4), .r(r4), .err_clr(err_clr4),
      .q(q4), .q_bar(qb4), .invalid(inv4), .err_sticky(err4)
`ifdef NOR_LATCH_VIOL_CNT_EN
      , .viol_cnt(viol4)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic eq, input logic eqb, input logic einv);
      check({tag, ".q"}, 32'(q), 32'(eq));
      check({tag, ".q_bar"}, 32'(q_bar), 32'(eqb));
      check({tag, ".invalid"}, 32'(invalid), 32'(einv));
   endtask

   initial begin
      rst_n = 1'b0; rst4_n = 1'b0;
      s = 1'b1; r = 1'b1; err_clr = 1'b0;
      s4 = '1; r4 = '1; err_clr4 = 1'b0;
      tick(2);
      check1("reset", 1'b0, 1'b1, 1'b0);
      check("reset.err", 32'(err_sticky), 32'd0);
      check("reset4.q_bar", 32'(qb4), 32'hf);
`ifdef NOR_LATCH_VIOL_CNT_EN
      check("reset.viol", 32'(viol1), 32'd0);
`endif

      rst_n = 1'b1; s = 1'b0; r = 1'b0;
      tick(10);
      check1("hold_after_reset", 1'b0, 1'b1, 1'b0);
      r = 1'b1;
      tick(10);
      check1("reset_cmd", 1'b0, 1'b1, 1'b0);
      s = 1'b1; r = 1'b0;
      tick(10);
      check1("set_cmd", 1'b1, 1'b0, 1'b0);
      s = 1'b0;
      tick(10);
      check1("hold_set", 1'b1, 1'b0, 1'b0);
      s = 1'b1; r = 1'b1;
      tick(10);
      check1("forbidden", 1'b0, 1'b0, 1'b1);
      check("forbidden.err", 32'(err_sticky), 32'd1);
`ifdef NOR_LATCH_VIOL_CNT_EN
      check("forbidden.viol", 32'(viol1), 32'd1);
`endif
      s = 1'b0; r = 1'b0;
      tick();
      check1("resolve", 1'b0, 1'b1, 1'b0);
      check("resolve.err_held", 32'(err_sticky), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clear.err", 32'(err_sticky), 32'd0);
`ifdef NOR_LATCH_VIOL_CNT_EN
      check("clear.viol", 32'(viol1), 32'd0);
`endif

      // Single-cycle set pulse: not visible before the edge that samples it.
      s = 1'b1;
      #3;
      check("latency.before", 32'(q), 32'd0);
      tick();
      s = 1'b0;
      check("latency.after", 32'(q), 32'd1);
      tick();
      check("latency.hold", 32'(q), 32'd1);

      s = 1'b1; r = 1'b1; err_clr = 1'b1;
      tick();
      check("entry_with_clr.err", 32'(err_sticky), 32'd1);
      tick();
      check("staying_forbidden_clr.err", 32'(err_sticky), 32'd0);
      check("staying_forbidden.inv", 32'(invalid), 32'd1);
      s = 1'b0; r = 1'b0;
      tick();
      err_clr = 1'b0;
      check("clr_alone.err", 32'(err_sticky), 32'd0);

      s = 1'b1; r = 1'b1;
      tick();
      r = 1'b0;
      tick();
      check1("forbidden_to_set", 1'b1, 1'b0, 1'b0);
      r = 1'b1;
      tick();
      s = 1'b0;
      tick();
      check1("forbidden_to_reset", 1'b0, 1'b1, 1'b0);
      check("reentry.err", 32'(err_sticky), 32'd1);

      rst_n = 1'b0; s = 1'b1; r = 1'b0; err_clr = 1'b0;
      tick();
      check1("reset_override", 1'b0, 1'b1, 1'b0);
      check("reset_override.err", 32'(err_sticky), 32'd0);
      rst_n = 1'b1; s = 1'b0;

      // Mixed commands per bit: b0 forbidden, b1 reset, b2 set, b3 hold.
      rst4_n = 1'b1; s4 = 4'b0101; r4 = 4'b0011;
      tick();
      check("mix.q", 32'(q4), 32'h4);
      check("mix.q_bar", 32'(qb4), 32'ha);
      check("mix.invalid", 32'(inv4), 32'h1);
      check("mix.err", 32'(err4), 32'd1);
`ifdef NOR_LATCH_VIOL_CNT_EN
      check("mix.viol", 32'(viol4), 32'd1);
      s4 = '0; r4 = '0; err_clr4 = 1'b1;
      tick();
      err_clr4 = 1'b0;
      check("cnt.clear0", 32'(viol4), 32'd0);
      s4 = '1; r4 = '1;
      tick();
      check("cnt.sat", 32'(viol4), 32'd3);
      s4 = '0; r4 = '0;
      tick();
      s4 = '1; r4 = '1;
      tick();
      check("cnt.sat_repeat", 32'(viol4), 32'd3);
      s4 = '0; r4 = '0; err_clr4 = 1'b1;
      tick();
      err_clr4 = 1'b0;
      check("cnt.clear", 32'(viol4), 32'd0);
      s4 = 4'b0011; r4 = 4'b0011; err_clr4 = 1'b1;
      tick();
      err_clr4 = 1'b0;
      check("cnt.clr_with_entry", 32'(viol4), 32'd2);
`else
      s4 = '0; r4 = '0;
      tick();
      check("mix.resolve_q_bar", 32'(qb4), 32'hb);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
